// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, immediate format codes and skid-buffer states for imm_gen_pipe.
package imm_gen_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_CSR = 3'd6
   } imm_fmt_t;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder: instruction word -> sign-extended immediate, format, illegal flag.
// Build option IMM_GEN_ZICSR_EN decodes SYSTEM/CSR instructions as zimm with format CSR.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   output logic [XLEN-1:0] o_imm,
   output imm_fmt_t        o_fmt,
   output logic            o_illegal
);

   logic [31:0] w_imm32;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_imm32   = '0;
      o_fmt     = FMT_R;
      o_illegal = 1'b0;
      case (i_instr[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
            w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            o_fmt   = FMT_I;
         end
         OPC_STORE: begin
            w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            o_fmt   = FMT_S;
         end
         OPC_BRANCH: begin
            w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            o_fmt   = FMT_B;
         end
         OPC_LUI, OPC_AUIPC: begin
            w_imm32 = {i_instr[31:12], 12'b0};
            o_fmt   = FMT_U;
         end
         OPC_JAL: begin
            w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            o_fmt   = FMT_J;
         end
         OPC_OP: begin
            w_imm32 = '0;
            o_fmt   = FMT_R;
         end
         OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
            if (i_instr[14:12] != 3'b000) begin
               w_imm32 = {27'd0, i_instr[19:15]};
               o_fmt   = FMT_CSR;
            end else begin
               w_imm32 = '0;
               o_fmt   = FMT_I;
            end
`else
            w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            o_fmt   = FMT_I;
`endif
         end
         default: begin
            o_illegal = 1'b1;
         end
      endcase
   end

   // zimm has bit 31 clear, so the signed widening also zero-extends it.
   assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer and a saturating illegal-opcode counter.
// Build option IMM_GEN_ZICSR_EN enables CSR zimm decoding in imm_decode.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int TAG_W     = 32,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_imm,
   output logic [2:0]           out_fmt,
   output logic                 out_illegal,
   output logic [TAG_W-1:0]     out_tag,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic [XLEN-1:0]      w_dec_imm;
   imm_fmt_t             w_dec_fmt;
   logic                 w_dec_illegal;

   skid_state_t          r_state;
   skid_state_t          w_state_nxt;
   logic                 w_in_xfer;
   logic                 w_out_xfer;
   logic                 w_load_out_in;
   logic                 w_load_out_skid;
   logic                 w_load_skid;

   logic [XLEN-1:0]      r_out_imm;
   imm_fmt_t             r_out_fmt;
   logic                 r_out_illegal;
   logic [TAG_W-1:0]     r_out_tag;
   logic [XLEN-1:0]      r_skid_imm;
   imm_fmt_t             r_skid_fmt;
   logic                 r_skid_illegal;
   logic [TAG_W-1:0]     r_skid_tag;
   logic [ERR_CNT_W-1:0] r_err_count;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .i_instr   (in_instr),
      .o_imm     (w_dec_imm),
      .o_fmt     (w_dec_fmt),
      .o_illegal (w_dec_illegal)
   );

   // Both handshakes derive from the state register only, so in_ready never depends on out_ready.
   assign w_in_xfer  = in_valid  & (r_state != SKID_FULL);
   assign w_out_xfer = out_ready & (r_state != SKID_EMPTY);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= SKID_EMPTY;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SKID_EMPTY: if (w_in_xfer) w_state_nxt = SKID_ONE;
         SKID_ONE: begin
            if (w_in_xfer && !w_out_xfer)      w_state_nxt = SKID_FULL;
            else if (!w_in_xfer && w_out_xfer) w_state_nxt = SKID_EMPTY;
         end
         SKID_FULL:  if (w_out_xfer) w_state_nxt = SKID_ONE;
         default:    w_state_nxt = SKID_EMPTY;
      endcase
   end

   always_comb begin
      in_ready        = (r_state != SKID_FULL);
      out_valid       = (r_state != SKID_EMPTY);
      w_load_out_in   = 1'b0;
      w_load_out_skid = 1'b0;
      w_load_skid     = 1'b0;
      case (r_state)
         SKID_EMPTY: w_load_out_in = w_in_xfer;
         SKID_ONE: begin
            if (w_out_xfer) w_load_out_in = w_in_xfer;
            else            w_load_skid   = w_in_xfer;
         end
         SKID_FULL:  w_load_out_skid = w_out_xfer;
         default: ;
      endcase
   end

   // NOTE: the payload registers are reset too, so no result from before reset can ever reappear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_imm      <= '0;
         r_out_fmt      <= FMT_R;
         r_out_illegal  <= 1'b0;
         r_out_tag      <= '0;
         r_skid_imm     <= '0;
         r_skid_fmt     <= FMT_R;
         r_skid_illegal <= 1'b0;
         r_skid_tag     <= '0;
      end else begin
         if (w_load_out_in) begin
            r_out_imm     <= w_dec_imm;
            r_out_fmt     <= w_dec_fmt;
            r_out_illegal <= w_dec_illegal;
            r_out_tag     <= in_tag;
         end else if (w_load_out_skid) begin
            r_out_imm     <= r_skid_imm;
            r_out_fmt     <= r_skid_fmt;
            r_out_illegal <= r_skid_illegal;
            r_out_tag     <= r_skid_tag;
         end
         if (w_load_skid) begin
            r_skid_imm     <= w_dec_imm;
            r_skid_fmt     <= w_dec_fmt;
            r_skid_illegal <= w_dec_illegal;
            r_skid_tag     <= in_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count <= '0;
      end else if (w_in_xfer && w_dec_illegal && (r_err_count != '1)) begin
         r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
   end

   assign out_imm     = r_out_imm;
   assign out_fmt     = r_out_fmt;
   assign out_illegal = r_out_illegal;
   assign out_tag     = r_out_tag;
   assign err_count   = r_err_count;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe; an XLEN=64 copy shares the stimulus.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_tag;
   logic        out_ready;

   logic        in_ready,   in_ready64;
   logic        out_valid,  out_valid64;
   logic [31:0] out_imm;
   logic [63:0] out_imm64;
   logic [2:0]  out_fmt,    out_fmt64;
   logic        out_illegal, out_illegal64;
   logic [31:0] out_tag,    out_tag64;
   logic [7:0]  err_count,  err_count64;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ERR_CNT_W(8)) u_dut (
      .clk (clk), .rst_n (rst_n),
      .in_valid (in_valid), .in_ready (in_ready), .in_instr (in_instr), .in_tag (in_tag),
      .out_valid (out_valid), .out_ready (out_ready), .out_imm (out_imm), .out_fmt (out_fmt),
      .out_illegal (out_illegal), .out_tag (out_tag), .err_count (err_count)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ERR_CNT_W(8)) u_dut64 (
      .clk (clk), .rst_n (rst_n),
      .in_valid (in_valid), .in_ready (in_ready64), .in_instr (in_instr), .in_tag (in_tag),
      .out_valid (out_valid64), .out_ready (out_ready), .out_imm (out_imm64), .out_fmt (out_fmt64),
      .out_illegal (out_illegal64), .out_tag (out_tag64), .err_count (err_count64)
   );

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One instruction through an idle pipe with out_ready=1.
   task automatic vec(input string name, input logic [31:0] instr, input logic [63:0] exp64,
                      input logic [2:0] fmt, input logic ill, input logic [31:0] tag);
      in_valid = 1'b1;
      in_instr = instr;
      in_tag   = tag;
      step();
      in_valid = 1'b0;
      check({name, "_valid"},   64'(out_valid),   64'd1);
      check({name, "_imm"},     64'(out_imm),     64'(exp64[31:0]));
      check({name, "_imm64"},   out_imm64,        exp64);
      check({name, "_fmt"},     64'(out_fmt),     64'(fmt));
      check({name, "_illegal"}, 64'(out_illegal), 64'(ill));
      check({name, "_tag"},     64'(out_tag),     64'(tag));
      step();
      check({name, "_drained"}, 64'(out_valid),   64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_imm",   64'(out_imm),   64'd0);
      check("rst_out_fmt",   64'(out_fmt),   64'd0);
      check("rst_out_tag",   64'(out_tag),   64'd0);
      check("rst_err_count", 64'(err_count), 64'd0);
      #1 rst_n = 1'b1;
      step();
      out_ready = 1'b1;

      vec("addi",  32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0, 32'h000000A1);
      vec("sw",    32'hFE112E23, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0, 32'h000000A2);
      vec("beq",   32'h00000463, 64'h00000000_00000008, 3'd3, 1'b0, 32'h000000A3);
      vec("lui",   32'h123452B7, 64'h00000000_12345000, 3'd4, 1'b0, 32'h000000A4);
      vec("lui_n", 32'h800002B7, 64'hFFFFFFFF_80000000, 3'd4, 1'b0, 32'h000000A5);
      vec("jal",   32'h0080006F, 64'h00000000_00000008, 3'd5, 1'b0, 32'h000000A6);
      vec("add",   32'h00B50533, 64'h00000000_00000000, 3'd0, 1'b0, 32'h000000A7);
`ifdef IMM_GEN_ZICSR_EN
      vec("csrrw", 32'h34029073, 64'h00000000_00000005, 3'd6, 1'b0, 32'h000000A8);
`else
      vec("csrrw", 32'h34029073, 64'h00000000_00000340, 3'd1, 1'b0, 32'h000000A8);
`endif
      check("err_none_yet", 64'(err_count), 64'd0);

      // Back-pressure: tags 1,2 fill output + skid, tag 3 is held off.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFFF00093;
      in_tag    = 32'd1;
      step();
      check("bp_ready_after1", 64'(in_ready), 64'd1);
      check("bp_tag_after1",   64'(out_tag),  64'd1);
      in_tag = 32'd2;
      step();
      check("bp_ready_after2", 64'(in_ready), 64'd0);
      check("bp_tag_after2",   64'(out_tag),  64'd1);
      in_tag = 32'd3;
      step();
      check("bp_ready_hold",   64'(in_ready), 64'd0);
      check("bp_tag_hold",     64'(out_tag),  64'd1);
      out_ready = 1'b1;
      step();
      check("bp_valid_2",      64'(out_valid), 64'd1);
      check("bp_tag_2",        64'(out_tag),   64'd2);
      check("bp_ready_reopen", 64'(in_ready),  64'd1);
      step();
      in_valid = 1'b0;
      check("bp_valid_3",      64'(out_valid), 64'd1);
      check("bp_tag_3",        64'(out_tag),   64'd3);
      step();
      check("bp_empty",        64'(out_valid), 64'd0);

      // Illegal opcode streamed 300 times; counter saturates at 255.
      in_valid = 1'b1;
      in_instr = 32'h0000007F;
      in_tag   = 32'hBAD;
      for (int i = 0; i < 300; i++) begin
         step();
         if (i == 0)   check("err_first", 64'(err_count), 64'd1);
         if (i == 254) check("err_255",   64'(err_count), 64'd255);
         if (i == 150) check("ill_ready", 64'(in_ready),  64'd1);
      end
      check("err_saturated", 64'(err_count),   64'd255);
      check("ill_flag",      64'(out_illegal), 64'd1);
      check("ill_imm",       64'(out_imm),     64'd0);
      check("ill_fmt",       64'(out_fmt),     64'd0);
      check("ill_err64",     64'(err_count64), 64'd255);
      in_valid = 1'b0;
      step();

      // Asynchronous reset while FULL.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00000463;
      in_tag    = 32'h11;
      step();
      in_tag = 32'h22;
      step();
      in_valid = 1'b0;
      check("full_ready",  64'(in_ready),  64'd0);
      check("full_valid",  64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_valid", 64'(out_valid), 64'd0);
      check("async_ready", 64'(in_ready),  64'd1);
      check("async_err",   64'(err_count), 64'd0);
      check("async_tag",   64'(out_tag),   64'd0);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      check("post_rst_valid", 64'(out_valid), 64'd0);
      step();
      check("post_rst_still", 64'(out_valid), 64'd0);
      vec("post_rst", 32'hFE112E23, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0, 32'h33);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate generator for the RV32I/RV64I decode path.
- Decodes every base-ISA immediate format (I, S, B, U, J, plus R with no immediate) and sign-extends the result to XLEN.
- Flags unknown opcodes and carries a sideband tag (PC or instruction id) alongside the result.
- Sits between fetch and the register-read/ALU stage. A 2-entry skid buffer lets it absorb downstream stalls without dropping or duplicating instructions.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag carried with each instruction.
- ERR_CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, instruction present on in_instr/in_tag.
- in_ready, output, 1, block can accept an instruction.
- in_instr, input, 32, raw instruction word.
- in_tag, input, TAG_W, sideband tag, passed through unchanged.
- out_valid, output, 1, out_* fields valid.
- out_ready, input, 1, consumer accepts out_*.
- out_imm, output, XLEN, sign-extended immediate.
- out_fmt, output, 3, format code: R=0, I=1, S=2, B=3, U=4, J=5, CSR=6.
- out_illegal, output, 1, opcode not recognised.
- out_tag, output, TAG_W, tag of the instruction on out_imm.
- err_count, output, ERR_CNT_W, saturating count of accepted illegal instructions.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0, every register clears:
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, err_count=0, skid empty, in_ready=1.
  - Reset mid-operation discards both the output entry and the skid entry; no partial result survives.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Latency is 1 cycle: an instruction accepted on edge N appears on out_* after edge N, when the output register is free or being drained.
- Decode is combinational on in_instr; the result is registered. Opcode [6:0] mapping:
  - 0000011, 0010011, 1100111 → I: sext(instr[31:20]). OP-IMM shifts use the full 12-bit field.
  - 0100011 → S: sext({instr[31:25], instr[11:7]}).
  - 1100011 → B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 0110111, 0010111 → U: sext({instr[31:12], 12'b0}). For XLEN=64, bit 31 extends into the upper 32 bits.
  - 1101111 → J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 0110011 → R: imm=0.
  - 1110011 → I (see Optional Feature).
  - All other opcodes: imm=0, fmt=R, illegal=1.
- Skid buffer:
  - States: EMPTY (out_valid=0), ONE (out_valid=1, skid empty), FULL (out_valid=1, skid valid).
  - in_ready = !skid_valid, registered, never combinationally dependent on out_ready.
  - EMPTY + input transfer → ONE.
  - ONE + input transfer + no output transfer → FULL; the new entry goes to skid.
  - ONE + input transfer + output transfer → ONE; output reloads from input.
  - ONE + output transfer only → EMPTY.
  - FULL + output transfer → ONE; output loads from skid and skid clears. Input is blocked (in_ready=0) that cycle.
  - FULL + no output transfer → hold everything.
- Ordering is strictly FIFO. No instruction is lost or duplicated.
- out_* stay stable while out_valid=1 and out_ready=0.
- err_count increments by 1 on each input transfer whose decode is illegal. It saturates at all-ones and never wraps.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- Defined: opcode 1110011 with funct3≠000 gives fmt=CSR and imm = zero-extended instr[19:15] (zimm). funct3=000 (ECALL/EBREAK) gives fmt=I, imm=0.
- Undefined: opcode 1110011 is always decoded as I-format sext(instr[31:20]). CSR code 6 is never produced.

Decomposition:
- Shared package imm_gen_pkg holds:
  - Opcode constants (OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_SYSTEM).
  - The 3-bit format enum imm_fmt_t.
- One combinational sub-module, imm_decode (in_instr → imm, fmt, illegal). The top owns the skid buffer and the counter.

Test Plan:
- Reset, then in_instr=0xFFF00093 (addi x1,x0,-1) with out_ready=1 → next cycle out_imm=0xFFFFFFFF, fmt=1, illegal=0, tag echoed.
- 0xFE112E23 (sw x1,-4(x2)) → imm 0xFFFFFFFC, fmt=2. 0x00000463 (beq +8) → imm 0x00000008, fmt=3. 0x123452B7 (lui) → imm 0x12345000, fmt=4. With XLEN=64, 0x800002B7 → imm 0xFFFFFFFF80000000.
- Back-to-back tags 1,2,3 with out_ready=0 → in_ready drops after tags 1 and 2 are accepted; tag 3 is held. Raise out_ready → outputs 1,2,3 in order, no gaps or duplicates.
- 0x0000007F, repeated 300 times with ERR_CNT_W=8 → every result illegal=1, imm=0; err_count stops at 255.
- Assert rst_n=0 in FULL state → out_valid=0 and in_ready=1 immediately (async); no stale output after release.
- 0x34029073 (csrrw x0,mscratch,x5): with IMM_GEN_ZICSR_EN → fmt=6, imm=5. Without it → fmt=1, imm=0x00000340.
